// File: rtl/led_trace_monitor.sv
// led_trace_monitor: timestamps every change of a LED bus inside a capture
// window and buffers {value,time} events in a first-word-fall-through FIFO
// that a host drains through a valid/ready port.
// Optional build macro: LED_MON_DEGLITCH_EN (record a change only after the
// new value has been stable for two consecutive capture cycles).
module led_trace_monitor #(
    parameter int unsigned LED_W  = 8,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WINDOW = 650
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iEnable,
    input  logic [LED_W-1:0]           iLed,
    output logic                       oEvtValid,
    output logic [LED_W-1:0]           oEvtLed,
    output logic [TS_W-1:0]            oEvtTime,
    input  logic                       iEvtReady,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oOverflow,
    output logic                       oDone
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic              en_q;
    logic [TS_W-1:0]   timer_q, timer_d;
    logic [LED_W-1:0]  prev_q, prev_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic [LED_W-1:0]  mem_led_q [DEPTH];
    logic [TS_W-1:0]   mem_ts_q  [DEPTH];

    logic              push_req, push, pop, full;
    logic [LED_W-1:0]  push_led;
    logic [TS_W-1:0]   push_time;

`ifdef LED_MON_DEGLITCH_EN
    logic              cand_v_q, cand_v_d;
    logic [LED_W-1:0]  cand_led_q, cand_led_d;
    logic [TS_W-1:0]   cand_t_q, cand_t_d;
`endif

    // Window FSM: start only on a registered rising edge of iEnable from idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (iEnable && !en_q) state_d = StArm;
            StArm:     state_d = StCapture;
            StCapture: if (timer_q == TS_W'(WINDOW - 1) || !iEnable) state_d = StDone;
            StDone:    if (!iEnable) state_d = StIdle;
        endcase
    end

    // Change detection, timer and event generation.
    always_comb begin
        timer_d   = timer_q;
        prev_d    = prev_q;
        push_req  = 1'b0;
        push_led  = iLed;
        push_time = timer_q;
`ifdef LED_MON_DEGLITCH_EN
        cand_v_d   = cand_v_q;
        cand_led_d = cand_led_q;
        cand_t_d   = cand_t_q;
`endif
        if (state_q == StArm) begin
            timer_d = '0;
            prev_d  = iLed;
`ifdef LED_MON_DEGLITCH_EN
            cand_v_d = 1'b0;
`endif
        end else if (state_q == StCapture) begin
            if (timer_q != '1) timer_d = timer_q + TS_W'(1);
`ifdef LED_MON_DEGLITCH_EN
            // A new value becomes a candidate; it is committed with its first
            // cycle's timestamp only if seen again on the next cycle.
            cand_v_d = 1'b0;
            if (iLed != prev_q) begin
                if (cand_v_q && iLed == cand_led_q) begin
                    push_req  = 1'b1;
                    push_led  = cand_led_q;
                    push_time = cand_t_q;
                    prev_d    = iLed;
                end else begin
                    cand_v_d   = 1'b1;
                    cand_led_d = iLed;
                    cand_t_d   = timer_q;
                end
            end
`else
            push_req = (iLed != prev_q);
            prev_d   = iLed;
`endif
        end
    end

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && iEvtReady;
    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    assign push = push_req && (!full || pop);

    // State, pointers, occupancy and sticky overflow; ARM flushes the buffer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            timer_q <= '0;
            prev_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= iEnable;
            timer_q <= timer_d;
            prev_q  <= prev_d;
            if (state_q == StArm) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (pop) rptr_q <= rptr_q + AW'(1);
                if (push) wptr_q <= wptr_q + AW'(1);
                if (push && !pop) count_q <= count_q + CW'(1);
                else if (!push && pop) count_q <= count_q - CW'(1);
                if (push_req && full && !pop) ovf_q <= 1'b1;
            end
        end
    end

`ifdef LED_MON_DEGLITCH_EN
    // Pending-change candidate for the deglitch filter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cand_v_q   <= 1'b0;
            cand_led_q <= '0;
            cand_t_q   <= '0;
        end else begin
            cand_v_q   <= cand_v_d;
            cand_led_q <= cand_led_d;
            cand_t_q   <= cand_t_d;
        end
    end
`endif

    // Event storage; contents need no reset since outputs are gated by valid.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_led_q[wptr_q] <= push_led;
            mem_ts_q[wptr_q]  <= push_time;
        end
    end

    assign oEvtValid = (count_q != '0);
    assign oEvtLed   = oEvtValid ? mem_led_q[rptr_q] : '0;
    assign oEvtTime  = oEvtValid ? mem_ts_q[rptr_q] : '0;
    assign oCount    = count_q;
    assign oOverflow = ovf_q;
    assign oDone     = (state_q == StDone);

endmodule

// File: tb/tb_led_trace_monitor.sv
// Bench for led_trace_monitor: a queue-based model of the window/buffer
// behaviour checked every cycle, plus directed scenarios with literal values.
module tb_led_trace_monitor;

    localparam int unsigned LED_W  = 8;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WINDOW = 20;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             iEnable;
    logic [LED_W-1:0] iLed;
    logic             iEvtReady;
    logic             oEvtValid;
    logic [LED_W-1:0] oEvtLed;
    logic [TS_W-1:0]  oEvtTime;
    logic [2:0]       oCount;
    logic             oOverflow;
    logic             oDone;

    led_trace_monitor #(
        .LED_W (LED_W),
        .TS_W  (TS_W),
        .DEPTH (DEPTH),
        .WINDOW(WINDOW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iEnable  (iEnable),
        .iLed     (iLed),
        .oEvtValid(oEvtValid),
        .oEvtLed  (oEvtLed),
        .oEvtTime (oEvtTime),
        .iEvtReady(iEvtReady),
        .oCount   (oCount),
        .oOverflow(oOverflow),
        .oDone    (oDone)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: window phase, timer, baseline and the event list as a queue.
    typedef struct {
        logic [LED_W-1:0] led;
        logic [TS_W-1:0]  t;
    } ev_t;

    ev_t         m_q[$];
    int          m_phase;   // 0 idle, 1 arm, 2 capture, 3 done
    int          m_timer;
    logic [7:0]  m_prev;
    logic        m_en_prev;
    logic        m_ovf;
    bit          m_started = 1'b0;

    always @(posedge Clock) begin
        bit have_ev;
        bit do_pop;
        if (Reset) begin
            m_q.delete();
            m_phase = 0; m_timer = 0; m_prev = '0; m_en_prev = 1'b0; m_ovf = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            have_ev = 1'b0;
            do_pop  = (m_q.size() != 0) && iEvtReady;
            case (m_phase)
                0: if (iEnable && !m_en_prev) m_phase = 1;
                1: begin
                    m_q.delete(); m_ovf = 1'b0; m_timer = 0; m_prev = iLed;
                    do_pop = 1'b0; m_phase = 2;
                end
                2: begin
                    if (iLed != m_prev) have_ev = 1'b1;
                    if (m_timer == int'(WINDOW) - 1 || !iEnable) m_phase = 3;
                    if (have_ev) begin
                        if (do_pop) void'(m_q.pop_front());
                        do_pop = 1'b0;
                        if (m_q.size() < DEPTH) m_q.push_back('{led: iLed, t: TS_W'(m_timer)});
                        else m_ovf = 1'b1;
                    end
                    m_prev = iLed;
                    if (m_timer < 65535) m_timer++;
                end
                default: if (!iEnable) m_phase = 0;
            endcase
            if (do_pop) void'(m_q.pop_front());
            m_en_prev = iEnable;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge Clock) begin
        if (m_started) begin
            check("m_valid", 32'(oEvtValid), 32'(m_q.size() != 0));
            check("m_count", 32'(oCount), 32'(m_q.size()));
            check("m_led", 32'(oEvtLed), (m_q.size() != 0) ? 32'(m_q[0].led) : 32'd0);
            check("m_time", 32'(oEvtTime), (m_q.size() != 0) ? 32'(m_q[0].t) : 32'd0);
            check("m_ovf", 32'(oOverflow), 32'(m_ovf));
            check("m_done", 32'(oDone), 32'(m_phase == 3));
        end
    end

    // Advance n clock cycles; returns 2 time units after the last rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask

    initial begin
        Reset = 1'b1; iEnable = 1'b0; iLed = 8'h00; iEvtReady = 1'b0;
        wait_cyc(2);
        check("rst_valid", 32'(oEvtValid), 32'd0);
        check("rst_count", 32'(oCount), 32'd0);
        check("rst_ovf", 32'(oOverflow), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_led", 32'(oEvtLed), 32'd0);
        check("rst_time", 32'(oEvtTime), 32'd0);
        Reset = 1'b0;
        wait_cyc(1);

        // Two changes at capture cycles 3 and 10.
        iEnable = 1'b1;
        wait_cyc(2);                 // capture cycle 0
        wait_cyc(3); iLed = 8'h01;   // cycle 3
        wait_cyc(7); iLed = 8'h03;   // cycle 10
        wait_cyc(1);
        check("t2_count", 32'(oCount), 32'd2);
        iEvtReady = 1'b1;
        check("t2_ev0_led", 32'(oEvtLed), 32'h01);
        check("t2_ev0_time", 32'(oEvtTime), 32'd3);
        wait_cyc(1);
        check("t2_ev1_led", 32'(oEvtLed), 32'h03);
        check("t2_ev1_time", 32'(oEvtTime), 32'd10);
        wait_cyc(1);
        iEvtReady = 1'b0;
        check("t2_drained", 32'(oCount), 32'd0);

        // Window end at timer 19 with iEnable held; later change ignored.
        wait_cyc(6);                 // cycle 19
        check("t3_not_done", 32'(oDone), 32'd0);
        wait_cyc(1);
        check("t3_done", 32'(oDone), 32'd1);
        wait_cyc(5); iLed = 8'h07;   // would be cycle 25
        wait_cyc(2);
        check("t3_no_event", 32'(oCount), 32'd0);
        check("t3_still_done", 32'(oDone), 32'd1);

        // Six changes into a 4-deep buffer with no reader.
        iEnable = 1'b0;
        wait_cyc(2);
        iEnable = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 6; i++) begin
            wait_cyc(1);
            iLed = 8'(8'h10 + i);
        end
        wait_cyc(1);
        check("t4_count", 32'(oCount), 32'd4);
        check("t4_ovf", 32'(oOverflow), 32'd1);
        check("t4_head_led", 32'(oEvtLed), 32'h10);
        check("t4_head_time", 32'(oEvtTime), 32'd1);
        iEnable = 1'b0;
        wait_cyc(2);
        iEnable = 1'b1;
        wait_cyc(2);
        check("t4_arm_ovf", 32'(oOverflow), 32'd0);
        check("t4_arm_count", 32'(oCount), 32'd0);

        // Full buffer: pop and push in the same cycle.
        for (int i = 0; i < 4; i++) begin
            wait_cyc(1);
            iLed = 8'(8'h30 + i);
        end
        wait_cyc(1);                 // cycle 5
        check("t5_full", 32'(oCount), 32'd4);
        iEvtReady = 1'b1;
        iLed = 8'h34;
        wait_cyc(1);
        check("t5_count", 32'(oCount), 32'd4);
        check("t5_ovf", 32'(oOverflow), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("t5_order_led", 32'(oEvtLed), 32'(8'h30 + i));
            check("t5_order_time", 32'(oEvtTime), 32'(1 + i));
            wait_cyc(1);
        end
        check("t5_empty", 32'(oCount), 32'd0);
        iEvtReady = 1'b0;

        // Reset in the middle of a capture.
        iEnable = 1'b0;
        wait_cyc(2);
        iEnable = 1'b1;
        wait_cyc(3);
        iLed = 8'h55;
        wait_cyc(2);
        check("t6_pre_count", 32'(oCount), 32'd1);
        Reset = 1'b1; iEnable = 1'b0;
        wait_cyc(1);
        Reset = 1'b0;
        check("t6_count", 32'(oCount), 32'd0);
        check("t6_valid", 32'(oEvtValid), 32'd0);
        check("t6_done", 32'(oDone), 32'd0);
        wait_cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
